// File: rtl/mult_share_scheduler.sv
// Round-robin scheduler sharing one external combinational multiplier between
// NUM_REQ requesters, returning tagged products through a rigid stall-able pipeline.
module mult_share_scheduler #(
    parameter int WIDTH       = 8,
    parameter int NUM_REQ     = 4,
    parameter int PIPE_STAGES = 0,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         mult_a,
    output logic [WIDTH-1:0]         mult_b,
    input  logic [2*WIDTH-1:0]       mult_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [2*WIDTH-1:0]       rsp_data,
    output logic [15:0]              issue_count,
    output logic [2:0]               in_flight
);
    // S1 plus the extra delay stages; the last entry drives rsp_*
    localparam int NS = PIPE_STAGES + 1;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("mult_share_scheduler: NUM_REQ must be in 2..8");
        end
        if (PIPE_STAGES < 0 || PIPE_STAGES > 4) begin : g_bad_pipe_stages
            $error("mult_share_scheduler: PIPE_STAGES must be in 0..4");
        end
    endgenerate

    logic [IDW-1:0]     ptr_r;
    logic               s0_valid_r;
    logic [IDW-1:0]     s0_id_r;
    logic               stg_valid_r [NS];
    logic [IDW-1:0]     stg_id_r    [NS];
    logic [2*WIDTH-1:0] stg_data_r  [NS];

    logic               stall_s;
    logic               gnt_found_s;
    logic [IDW-1:0]     gnt_idx_s;
    logic [IDW-1:0]     cand_s;
    logic [IDW:0]       sum_s;
    logic [IDW-1:0]     ptr_next_s;
    logic               req_fire_s;
    logic               rsp_fire_s;

    // A response only leaves when the edge actually advances the pipeline
    assign stall_s    = (rsp_valid & ~rsp_ready) | ~enable;
    assign rsp_fire_s = rsp_valid & rsp_ready & enable;

    // First valid requester at or above ptr, wrapping around
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        sum_s       = '0;
        cand_s      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s = {1'b0, ptr_r} + (IDW+1)'(k);
            if (sum_s >= (IDW+1)'(NUM_REQ)) begin
                sum_s = sum_s - (IDW+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDW-1:0];
            if (!gnt_found_s && req_valid[cand_s]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s;
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // One-hot accept, suppressed during reset and stall
    always_comb begin
        req_ready = '0;
        if (!reset && !stall_s && gnt_found_s) begin
            req_ready[gnt_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    assign req_fire_s = |(req_valid & req_ready);
    assign ptr_next_s = (gnt_idx_s == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx_s + IDW'(1);

    // Operand capture, grant pointer and rigid result shift
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r      <= '0;
            mult_a     <= '0;
            mult_b     <= '0;
            s0_valid_r <= 1'b0;
            s0_id_r    <= '0;
            for (int k = 0; k < NS; k++) begin
                stg_valid_r[k] <= 1'b0;
                stg_id_r[k]    <= '0;
                stg_data_r[k]  <= '0;
            end
        end else if (!stall_s) begin
            // Operands are only reloaded on a transfer so the multiplier stays quiet when idle
            if (req_fire_s) begin
                mult_a     <= req_a[int'(gnt_idx_s)*WIDTH +: WIDTH];
                mult_b     <= req_b[int'(gnt_idx_s)*WIDTH +: WIDTH];
                s0_valid_r <= 1'b1;
                s0_id_r    <= gnt_idx_s;
                ptr_r      <= ptr_next_s;
            end else begin
                s0_valid_r <= 1'b0;
            end
            stg_valid_r[0] <= s0_valid_r;
            stg_id_r[0]    <= s0_id_r;
            stg_data_r[0]  <= mult_out;
            for (int k = 1; k < NS; k++) begin
                stg_valid_r[k] <= stg_valid_r[k-1];
                stg_id_r[k]    <= stg_id_r[k-1];
                stg_data_r[k]  <= stg_data_r[k-1];
            end
        end
    end

    // Accepted-request and outstanding-result counters
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_count <= 16'd0;
            in_flight   <= 3'd0;
        end else begin
            if (req_fire_s) begin
                issue_count <= issue_count + 16'd1;
            end
            case ({req_fire_s, rsp_fire_s})
                2'b10:   in_flight <= in_flight + 3'd1;
                2'b01:   in_flight <= in_flight - 3'd1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    assign rsp_valid = stg_valid_r[NS-1];
    assign rsp_id    = stg_id_r[NS-1];
    assign rsp_data  = stg_data_r[NS-1];

endmodule

// File: tb/tb_mult_share_scheduler.sv
// Directed bench for mult_share_scheduler: table of per-cycle vectors on a
// PIPE_STAGES=0 instance plus hand sequences for stall, reset and PIPE_STAGES=2.
module tb_mult_share_scheduler;
    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_ready;

    logic [3:0]  req_ready0, req_ready2;
    logic [7:0]  mult_a0, mult_b0, mult_a2, mult_b2;
    logic [15:0] mult_out0, mult_out2;
    logic        rsp_valid0, rsp_valid2;
    logic [1:0]  rsp_id0, rsp_id2;
    logic [15:0] rsp_data0, rsp_data2;
    logic [15:0] issue_count0, issue_count2;
    logic [2:0]  in_flight0, in_flight2;

    int n_checks = 0;
    int n_errors = 0;

    assign mult_out0 = {8'h00, mult_a0} * {8'h00, mult_b0};
    assign mult_out2 = {8'h00, mult_a2} * {8'h00, mult_b2};

    mult_share_scheduler #(.WIDTH(8), .NUM_REQ(4), .PIPE_STAGES(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready0),
        .req_a(req_a), .req_b(req_b),
        .mult_a(mult_a0), .mult_b(mult_b0), .mult_out(mult_out0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id0), .rsp_data(rsp_data0),
        .issue_count(issue_count0), .in_flight(in_flight0)
    );

    mult_share_scheduler #(.WIDTH(8), .NUM_REQ(4), .PIPE_STAGES(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready2),
        .req_a(req_a), .req_b(req_b),
        .mult_a(mult_a2), .mult_b(mult_b2), .mult_out(mult_out2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id2), .rsp_data(rsp_data2),
        .issue_count(issue_count2), .in_flight(in_flight2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        rr;
        logic [3:0]  rv;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  x_ready;
        logic        x_valid;
        logic [1:0]  x_id;
        logic [15:0] x_data;
        logic [2:0]  x_infl;
        logic [15:0] x_iss;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] A_S  = 32'h0000_0005;
    localparam logic [31:0] B_S  = 32'h0000_0007;
    localparam logic [31:0] A_RR = 32'h0403_0201;
    localparam logic [31:0] B_RR = 32'h0303_0303;
    localparam logic [31:0] B_BP = 32'h0002_0000;

    function automatic vec_t v(input logic rst, input logic en, input logic rr,
                               input logic [3:0] rv, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] xr, input logic xv, input logic [1:0] xid,
                               input logic [15:0] xd, input logic [2:0] xf, input logic [15:0] xi);
        vec_t t;
        t.rst = rst; t.en = en; t.rr = rr; t.rv = rv; t.a = a; t.b = b;
        t.x_ready = xr; t.x_valid = xv; t.x_id = xid; t.x_data = xd;
        t.x_infl = xf; t.x_iss = xi;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge and settle before sampling
    task automatic drive(input logic rst, input logic en, input logic rr,
                         input logic [3:0] rv, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        reset = rst; enable = en; rsp_ready = rr;
        req_valid = rv; req_a = a; req_b = b;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b1, 4'b1111, A_RR, B_RR);
        drive(1'b1, 1'b1, 1'b1, 4'b1111, A_RR, B_RR);
    endtask

    initial begin
        vec_t t;
        logic       en_c;
        logic [3:0] one4;
        logic [3:0] exp_r;
        int         exp_id;

        reset = 1'b1; enable = 1'b1; rsp_ready = 1'b1;
        req_valid = 4'b0000; req_a = 32'h0; req_b = 32'h0;
        one4 = 4'b0001;

        do_reset();
        check("reset req_ready", 32'(req_ready0), 32'h0);
        check("reset mult_a", 32'(mult_a0), 32'h0);
        check("reset mult_b", 32'(mult_b0), 32'h0);
        check("reset rsp_valid", 32'(rsp_valid0), 32'h0);
        check("reset rsp_id", 32'(rsp_id0), 32'h0);
        check("reset rsp_data", 32'(rsp_data0), 32'h0);
        check("reset issue_count", 32'(issue_count0), 32'h0);
        check("reset in_flight", 32'(in_flight0), 32'h0);
        check("reset rsp_valid p2", 32'(rsp_valid2), 32'h0);

        // single request 5*7
        tbl.push_back(v(0,1,1,4'b0001,A_S,B_S, 4'b0001,0,2'd0,16'd0, 3'd0,16'd0));
        tbl.push_back(v(0,1,1,4'b0000,A_S,B_S, 4'b0000,0,2'd0,16'd0, 3'd1,16'd1));
        tbl.push_back(v(0,1,1,4'b0000,A_S,B_S, 4'b0000,1,2'd0,16'd35,3'd1,16'd1));
        tbl.push_back(v(0,1,1,4'b0000,A_S,B_S, 4'b0000,0,2'd0,16'd0, 3'd0,16'd1));
        tbl.push_back(v(1,1,1,4'b1111,A_RR,B_RR, 4'b0000,0,2'd0,16'd0,3'd0,16'd0));
        tbl.push_back(v(1,1,1,4'b1111,A_RR,B_RR, 4'b0000,0,2'd0,16'd0,3'd0,16'd0));
        // round robin, all requesting
        tbl.push_back(v(0,1,1,4'b1111,A_RR,B_RR, 4'b0001,0,2'd0,16'd0, 3'd0,16'd0));
        tbl.push_back(v(0,1,1,4'b1111,A_RR,B_RR, 4'b0010,0,2'd0,16'd0, 3'd1,16'd1));
        tbl.push_back(v(0,1,1,4'b1111,A_RR,B_RR, 4'b0100,1,2'd0,16'd3, 3'd2,16'd2));
        tbl.push_back(v(0,1,1,4'b1111,A_RR,B_RR, 4'b1000,1,2'd1,16'd6, 3'd2,16'd3));
        tbl.push_back(v(0,1,1,4'b1111,A_RR,B_RR, 4'b0001,1,2'd2,16'd9, 3'd2,16'd4));
        tbl.push_back(v(0,1,1,4'b0000,A_RR,B_RR, 4'b0000,1,2'd3,16'd12,3'd2,16'd5));
        tbl.push_back(v(0,1,1,4'b0000,A_RR,B_RR, 4'b0000,1,2'd0,16'd3, 3'd1,16'd5));
        tbl.push_back(v(0,1,1,4'b0000,A_RR,B_RR, 4'b0000,0,2'd0,16'd0, 3'd0,16'd5));
        tbl.push_back(v(1,1,1,4'b1111,A_RR,B_RR, 4'b0000,0,2'd0,16'd0,3'd0,16'd0));
        tbl.push_back(v(1,1,1,4'b1111,A_RR,B_RR, 4'b0000,0,2'd0,16'd0,3'd0,16'd0));
        // back-pressure on requester 2 stream
        tbl.push_back(v(0,1,1,4'b0100,32'h000A_0000,B_BP, 4'b0100,0,2'd0,16'd0, 3'd0,16'd0));
        tbl.push_back(v(0,1,1,4'b0100,32'h000B_0000,B_BP, 4'b0100,0,2'd0,16'd0, 3'd1,16'd1));
        tbl.push_back(v(0,1,1,4'b0100,32'h000C_0000,B_BP, 4'b0100,1,2'd2,16'd20,3'd2,16'd2));
        for (int k = 0; k < 4; k++)
            tbl.push_back(v(0,1,0,4'b0100,32'h0063_0000,B_BP, 4'b0000,1,2'd2,16'd22,3'd2,16'd3));
        tbl.push_back(v(0,1,1,4'b0000,32'h0063_0000,B_BP, 4'b0000,1,2'd2,16'd22,3'd2,16'd3));
        tbl.push_back(v(0,1,1,4'b0000,32'h0063_0000,B_BP, 4'b0000,1,2'd2,16'd24,3'd1,16'd3));
        tbl.push_back(v(0,1,1,4'b0000,32'h0063_0000,B_BP, 4'b0000,0,2'd0,16'd0, 3'd0,16'd3));

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            drive(t.rst, t.en, t.rr, t.rv, t.a, t.b);
            check($sformatf("row%0d req_ready", i), 32'(req_ready0), 32'(t.x_ready));
            if (!t.rst) begin
                check($sformatf("row%0d rsp_valid", i), 32'(rsp_valid0), 32'(t.x_valid));
                if (t.x_valid) begin
                    check($sformatf("row%0d rsp_id", i), 32'(rsp_id0), 32'(t.x_id));
                    check($sformatf("row%0d rsp_data", i), 32'(rsp_data0), 32'(t.x_data));
                end
                check($sformatf("row%0d in_flight", i), 32'(in_flight0), 32'(t.x_infl));
                check($sformatf("row%0d issue_count", i), 32'(issue_count0), 32'(t.x_iss));
            end
        end
        // operands stay at the last accepted pair while idle
        check("idle mult_a hold", 32'(mult_a0), 32'd12);
        check("idle mult_b hold", 32'(mult_b0), 32'd2);

        // enable low for cycles 2..4 of a full round-robin stream
        do_reset();
        for (int c = 0; c < 8; c++) begin
            en_c = (c < 2 || c > 4) ? 1'b1 : 1'b0;
            drive(1'b0, en_c, 1'b1, 4'b1111, A_RR, B_RR);
            exp_r = en_c ? (one4 << (((c < 2) ? c : c - 3) % 4)) : 4'b0000;
            check($sformatf("en c%0d req_ready", c), 32'(req_ready0), 32'(exp_r));
            check($sformatf("en c%0d rsp_valid", c), 32'(rsp_valid0), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                exp_id = (c <= 5) ? 0 : c - 5;
                check($sformatf("en c%0d rsp_id", c), 32'(rsp_id0), 32'(exp_id));
                check($sformatf("en c%0d rsp_data", c), 32'(rsp_data0), 32'((exp_id + 1) * 3));
            end
            if (!en_c) begin
                check($sformatf("en c%0d in_flight", c), 32'(in_flight0), 32'd2);
                check($sformatf("en c%0d issue_count", c), 32'(issue_count0), 32'd2);
            end
        end

        // reset with two operations in flight
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 4'b1111, A_RR, B_RR);
        drive(1'b0, 1'b1, 1'b1, 4'b1111, A_RR, B_RR);
        drive(1'b1, 1'b1, 1'b1, 4'b1111, A_RR, B_RR);
        check("midrst in_flight before", 32'(in_flight0), 32'd2);
        check("midrst req_ready in reset", 32'(req_ready0), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 4'b1010, A_RR, B_RR);
        check("midrst grant", 32'(req_ready0), 32'b0010);
        check("midrst rsp_valid c3", 32'(rsp_valid0), 32'd0);
        check("midrst in_flight after", 32'(in_flight0), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 4'b0000, A_RR, B_RR);
        check("midrst rsp_valid c4", 32'(rsp_valid0), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 4'b0000, A_RR, B_RR);
        check("midrst rsp_valid c5", 32'(rsp_valid0), 32'd1);
        check("midrst rsp_id c5", 32'(rsp_id0), 32'd1);
        check("midrst rsp_data c5", 32'(rsp_data0), 32'd6);
        drive(1'b0, 1'b1, 1'b1, 4'b0000, A_RR, B_RR);
        check("midrst rsp_valid c6", 32'(rsp_valid0), 32'd0);
        check("midrst in_flight c6", 32'(in_flight0), 32'd0);

        // full-scale operands through the PIPE_STAGES=2 instance
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 4'b0001, 32'h0000_00FF, 32'h0000_00FF);
        check("wide req_ready", 32'(req_ready2), 32'b0001);
        for (int c = 1; c <= 5; c++) begin
            drive(1'b0, 1'b1, 1'b1, 4'b0000, 32'h0000_00FF, 32'h0000_00FF);
            check($sformatf("wide c%0d rsp_valid", c), 32'(rsp_valid2), (c == 4) ? 32'd1 : 32'd0);
            if (c == 2) begin
                check("wide p0 rsp_data", 32'(rsp_data0), 32'hFE01);
            end
            if (c == 4) begin
                check("wide rsp_id", 32'(rsp_id2), 32'd0);
                check("wide rsp_data", 32'(rsp_data2), 32'hFE01);
            end
        end
        check("wide issue_count", 32'(issue_count2), 32'd1);
        check("wide in_flight", 32'(in_flight2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mult_share_scheduler.md
Name: mult_share_scheduler

Overview:
- Round-robin scheduler that shares one combinational multiplier (`mult` instance, WIDTH x WIDTH -> 2*WIDTH) between NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and registers them onto the shared multiplier inputs.
- Returns each product with the requester ID through a fixed-latency, back-pressurable pipeline.
- Sits between the serial operand loaders and the component under exploration in the size-exploration top.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH.
- NUM_REQ, 4, number of requesters (2..8); ID width IDW = clog2(NUM_REQ).
- PIPE_STAGES, 0, extra result register stages after the product capture (0..4).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  global advance enable; low freezes all state.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  packed operand B; same packing as req_a.
- mult_a  output  WIDTH  registered operand A to the shared multiplier.
- mult_b  output  WIDTH  registered operand B to the shared multiplier.
- mult_out  input  2*WIDTH  combinational product of mult_a*mult_b.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accept.
- rsp_id  output  IDW  requester index of the result.
- rsp_data  output  2*WIDTH  product.
- issue_count  output  16  number of accepted requests; wraps 0xFFFF->0.
- in_flight  output  3  number of accepted requests not yet consumed.

Behaviour:
- Pipeline structure:
  - S0: mult_a, mult_b, s0_valid, s0_id.
  - S1: captures mult_out, s1_valid, s1_id.
  - S2..S(1+PIPE_STAGES): plain delay stages.
  - The last stage drives rsp_*.
- Latency: request accepted at edge t -> rsp_valid high after edge t+2+PIPE_STAGES, provided there is no stall.
- Stall: stall = (rsp_valid & ~rsp_ready) | ~enable.
  - On stall every stage holds its contents, the grant pointer holds, and req_ready = 0.
  - Pipeline is a rigid shift: no bubble collapsing.
- Grant, combinational:
  - When not stalled, the granted requester is the first i with req_valid[i], searching from ptr upward with wrap.
  - req_ready[i] = 1 for the granted i only.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Transfer: req_valid[i] & req_ready[i].
  - On transfer: S0 loads req_a/req_b slice i, s0_valid=1, s0_id=i, and ptr <= (i+1) mod NUM_REQ.
  - Not stalled and no transfer: s0_valid=0; mult_a/mult_b hold their previous values, so the multiplier does not toggle.
- Response: transfer when rsp_valid & rsp_ready. On an unstalled edge, the last stage advances.
- issue_count: +1 on each request transfer; holds otherwise.
- in_flight: +1 on request transfer, -1 on response transfer, unchanged when both or neither occur in the same cycle. Maximum is 2+PIPE_STAGES, so it never overflows 3 bits.
- Reset values:
  - All valids, ptr, mult_a, mult_b, rsp_id, rsp_data, issue_count and in_flight are 0.
  - req_ready is 0 during the reset cycle.
- Reset mid-operation discards all in-flight results; no rsp is produced for them.
- Fairness: a continuously asserted requester is granted at least once every NUM_REQ grants.
- Simultaneous: a request transfer and a response transfer in the same cycle are both legal at full throughput (1 op/cycle).
- Out-of-range: request IDs never exceed NUM_REQ-1. Unused PIPE_STAGES values are a synthesis-time error.

Test Plan:
- Reset, single request: reset 2 cycles; req_valid=0001, a=5, b=7, rsp_ready=1.
  - req_ready=0001 same cycle.
  - rsp_valid=1, rsp_id=0, rsp_data=35 exactly 2 cycles later.
  - issue_count=1; in_flight returns to 0.
- Round-robin: req_valid=1111 held, operands i: a=i+1, b=3, rsp_ready=1.
  - Grant order 0,1,2,3,0.
  - Responses (id,data) = (0,3),(1,6),(2,9),(3,12),(0,3) on consecutive cycles.
- Back-pressure: stream 3 requests, drop rsp_ready for 4 cycles after the first rsp.
  - rsp holds (id/data stable), req_ready=0 throughout the stall.
  - On release, remaining results emerge in order; no loss or duplication; in_flight peaks at 2.
- Wide operands, PIPE_STAGES=2: a=0xFF, b=0xFF.
  - rsp_data=0xFE01 exactly 4 cycles after accept.
- enable low for 3 cycles mid-stream: all state frozen, no grants. Resuming yields identical results shifted by 3 cycles.
- Reset mid-op with 2 ops in flight: no rsp_valid afterwards, in_flight=0, ptr=0, so the next grant with req_valid=1010 goes to requester 1.
